// File: rtl/bin_to_seg6_if.sv
// Request/result bundle between a value source and the 6-digit segment converter.
// The master drives the request; the slave returns the segment bus and status flags.
interface bin_to_seg6_if;
  logic        start;
  logic [19:0] value;
  logic        neg;
  logic [47:0] seg_out;
  logic        busy;
  logic        done;
  logic        err;

  modport master (output start, value, neg, input seg_out, busy, done, err);
  modport slave  (input start, value, neg, output seg_out, busy, done, err);
endinterface

// File: rtl/bin_to_seg6.sv
// Sequential double-dabble converter: 20-bit magnitude + sign to six 7-segment bytes.
// Fixed 21-cycle latency from start to done; seg_out only changes on the done edge.
module bin_to_seg6 #(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input logic           s_clk,
  input logic           s_reset,
  bin_to_seg6_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  localparam logic [47:0] BLANK_ALL = (SEG_ACTIVE_LOW != 0) ? 48'hFFFF_FFFF_FFFF : 48'h0;

  state_t      state;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [4:0]  cnt;
  logic        neg_r;
  logic        ovf_r;
  logic [47:0] seg_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [47:0] enc;

  assign bus.seg_out = seg_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Minus sits just left of the top shown digit; no minus for zero, which ovf also rules out.
  always_comb begin
    logic [2:0] msd;
    logic [7:0] code_v;
    logic       minus_on;
    int         minus_pos;
    enc      = '0;
    msd      = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) msd = 3'(i);
    end
    minus_on  = neg_r && (bcd != 24'd0);
    minus_pos = (BLANK_LZ != 0) ? int'(msd) + 1 : 5;
    for (int i = 0; i < 6; i++) begin
      code_v = 8'hFF;
      if (ovf_r)                                 code_v = 8'h86;
      else if (minus_on && i == minus_pos)       code_v = 8'hBF;
      else if (BLANK_LZ == 0 || i <= int'(msd))  code_v = seg_code(bcd[i*4 +: 4]);
      enc[i*8 +: 8] = (SEG_ACTIVE_LOW != 0) ? code_v : ~code_v;
    end
  end

  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      state  <= IDLE;
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      neg_r  <= 1'b0;
      ovf_r  <= 1'b0;
      seg_q  <= BLANK_ALL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin    <= bus.value;
            neg_r  <= bus.neg;
            ovf_r  <= (bus.value > 20'd999999) || (bus.neg && bus.value > 20'd99999);
            bcd    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
          cnt        <= cnt + 5'd1;
          if (cnt == 5'd19) state <= ENCODE;
        end
        ENCODE: begin
          seg_q  <= enc;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          err_q  <= ovf_r;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_seg6.sv
// Directed bench for bin_to_seg6: one blanking instance and one all-digits instance share stimulus.
module tb_bin_to_seg6;

  logic s_clk = 1'b0;
  logic s_reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  bin_to_seg6_if b1 ();
  bin_to_seg6_if b2 ();

  bin_to_seg6 #(.SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut (.s_clk(s_clk), .s_reset(s_reset), .bus(b1));
  bin_to_seg6 #(.SEG_ACTIVE_LOW(1), .BLANK_LZ(0)) u_dut_nb (.s_clk(s_clk), .s_reset(s_reset), .bus(b2));

  always #5 s_clk = ~s_clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [19:0] v, input logic n);
    b1.start = s; b1.value = v; b1.neg = n;
    b2.start = s; b2.value = v; b2.neg = n;
  endtask

  // Pulses start for one edge, then counts edges to done and cycles with busy high.
  task automatic run(input logic [19:0] v, input logic n, output int lat, output int busy_cnt);
    drive(1'b1, v, n);
    @(posedge s_clk); #1;
    drive(1'b0, v, n);
    lat = 0;
    busy_cnt = 0;
    while (!b1.done && lat < 40) begin
      if (b1.busy) busy_cnt++;
      @(posedge s_clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bc, dones;
    drive(1'b0, 20'd0, 1'b0);
    #12;
    check("reset_seg", b1.seg_out, 48'hFFFF_FFFF_FFFF);
    check("reset_flags", {45'd0, b1.busy, b1.done, b1.err}, 48'd0);
    @(negedge s_clk);
    s_reset = 1'b0;
    @(posedge s_clk); #1;

    run(20'd123456, 1'b0, lat, bc);
    check("full_latency", 48'(lat), 48'd21);
    check("full_busy_cycles", 48'(bc), 48'd21);
    check("full_seg", b1.seg_out, 48'hF9A4_B099_9282);
    check("full_err", {47'd0, b1.err}, 48'd0);
    check("full_busy_at_done", {47'd0, b1.busy}, 48'd0);
    @(posedge s_clk); #1;
    check("done_one_cycle", {47'd0, b1.done}, 48'd0);

    run(20'd42, 1'b0, lat, bc);
    check("lz_42", b1.seg_out, 48'hFFFF_FFFF_99A4);
    check("nolz_42", b2.seg_out, 48'hC0C0_C0C0_99A4);
    run(20'd42, 1'b1, lat, bc);
    check("neg_42", b1.seg_out, 48'hFFFF_FFBF_99A4);
    run(20'd0, 1'b1, lat, bc);
    check("neg_zero", b1.seg_out, 48'hFFFF_FFFF_FFC0);
    check("neg_zero_nolz", b2.seg_out, 48'hC0C0_C0C0_C0C0);

    run(20'd1000000, 1'b0, lat, bc);
    check("ovf_pos_latency", 48'(lat), 48'd21);
    check("ovf_pos_seg", b1.seg_out, 48'h8686_8686_8686);
    check("ovf_pos_err", {47'd0, b1.err}, 48'd1);
    run(20'd100000, 1'b1, lat, bc);
    check("ovf_neg_seg", b1.seg_out, 48'h8686_8686_8686);
    check("ovf_neg_err", {47'd0, b1.err}, 48'd1);
    run(20'd99999, 1'b1, lat, bc);
    check("neg_max_seg", b1.seg_out, 48'hBF90_9090_9090);
    check("neg_max_err", {47'd0, b1.err}, 48'd0);
    check("neg_max_nolz", b2.seg_out, 48'hBF90_9090_9090);

    // Second start 5 cycles in, then start held across the ENCODE edge: both must be ignored.
    drive(1'b1, 20'd123456, 1'b0);
    @(posedge s_clk); #1;
    drive(1'b0, 20'd123456, 1'b0);
    dones = 0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6)  drive(1'b1, 20'd7, 1'b0);
      if (c == 7)  drive(1'b0, 20'd7, 1'b0);
      if (c == 21) drive(1'b1, 20'd7, 1'b0);
      if (c == 22) drive(1'b0, 20'd7, 1'b0);
      @(posedge s_clk); #1;
      if (c == 10) check("hold_prev_seg", b1.seg_out, 48'hBF90_9090_9090);
      if (b1.done) begin dones++; lat = c; end
    end
    check("busy_start_dones", 48'(dones), 48'd1);
    check("busy_start_latency", 48'(lat), 48'd21);
    check("busy_start_seg", b1.seg_out, 48'hF9A4_B099_9282);
    check("encode_start_idle", {47'd0, b1.busy}, 48'd0);
    run(20'd7, 1'b0, lat, bc);
    check("after_done_seg", b1.seg_out, 48'hFFFF_FFFF_FFF8);

    drive(1'b1, 20'd123456, 1'b0);
    @(posedge s_clk); #1;
    drive(1'b0, 20'd123456, 1'b0);
    repeat (10) @(posedge s_clk);
    #2;
    s_reset = 1'b1;
    #1;
    check("midreset_seg", b1.seg_out, 48'hFFFF_FFFF_FFFF);
    check("midreset_flags", {45'd0, b1.busy, b1.done, b1.err}, 48'd0);
    @(negedge s_clk);
    s_reset = 1'b0;
    dones = 0;
    repeat (25) begin
      @(posedge s_clk); #1;
      if (b1.done) dones++;
    end
    check("midreset_no_done", 48'(dones), 48'd0);
    run(20'd42, 1'b0, lat, bc);
    check("post_reset_latency", 48'(lat), 48'd21);
    check("post_reset_seg", b1.seg_out, 48'hFFFF_FFFF_99A4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
